// File: rtl/bp_next_pc_if.sv
// Fetch/resolve signal bundle for bp_next_pc.
// The slave modport is the predictor. The master modport is the pipeline side,
// covering IF and ID.
interface bp_next_pc_if #(
  parameter int unsigned PC_W = 32
);
  logic            hazard;
  logic [PC_W-1:0] pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            id_valid;
  logic [PC_W-1:0] id_pc;
  logic            id_is_jump;
  logic            id_taken;
  logic [PC_W-1:0] id_target;
  logic            id_pred_taken;
  logic [PC_W-1:0] id_pred_target;
  logic            flush;

  modport master (
    output hazard, id_valid, id_pc, id_is_jump, id_taken, id_target,
           id_pred_taken, id_pred_target,
    input  pc, pred_taken, pred_target, flush
  );

  modport slave (
    input  hazard, id_valid, id_pc, id_is_jump, id_taken, id_target,
           id_pred_taken, id_pred_target,
    output pc, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/bp_next_pc.sv
// bp_next_pc: this block produces the fetch PC.
// A direct-mapped BTB with saturating counters predicts taken branches and jumps at
// fetch time. ID-stage resolution trains the table. On a mispredict, the block
// redirects the PC and raises flush.
// Optional macro BP_STATS_EN adds the stat_resolved and stat_mispred counter ports.
module bp_next_pc #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     ENTRIES  = 16,
  parameter int unsigned     CNT_W    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  bp_next_pc_if.slave bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);

  localparam int unsigned      IDX_W    = $clog2(ENTRIES);
  localparam int unsigned      TAG_W    = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];

  logic [PC_W-1:0]  pc_q, pc_d, pc_inc, id_inc;
  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             f_hit, r_hit, acc, mispredict;
  logic             pred_taken, alloc, cnt_we, tgt_we;
  logic [PC_W-1:0]  pred_target;
  logic [CNT_W-1:0] cnt_d;

  assign f_idx  = pc_q[IDX_W+1:2];
  assign f_tag  = pc_q[PC_W-1:IDX_W+2];
  assign r_idx  = bus.id_pc[IDX_W+1:2];
  assign r_tag  = bus.id_pc[PC_W-1:IDX_W+2];
  assign pc_inc = pc_q + PC_STEP;
  assign id_inc = bus.id_pc + PC_STEP;

  // Fetch-side lookup on the current PC.
  // The table is read from registers, so an update in the same cycle is not seen
  // until the next cycle.
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && cnt_q[f_idx][CNT_W-1];
  assign pred_target = f_hit ? tgt_q[f_idx] : pc_inc;

  // Resolution in ID.
  // When hazard is set, ID holds its instruction and will present it again,
  // so the resolution is ignored for this cycle.
  assign acc        = bus.id_valid && !bus.hazard;
  assign r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign mispredict = acc && ((bus.id_taken != bus.id_pred_taken) ||
                              (bus.id_taken && (bus.id_target != bus.id_pred_target)));

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.flush       = mispredict;

  // Next-PC priority: a mispredict redirect wins, then a stall, then the prediction.
  always_comb begin
    if (mispredict)      pc_d = bus.id_taken ? bus.id_target : id_inc;
    else if (bus.hazard) pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
    else                 pc_d = pc_inc;
  end

  // Training decision for the entry that the resolved PC maps to.
  always_comb begin
    cnt_d  = cnt_q[r_idx];
    cnt_we = 1'b0;
    tgt_we = 1'b0;
    alloc  = 1'b0;
    if (acc) begin
      if (r_hit) begin
        cnt_we = 1'b1;
        if (bus.id_is_jump) begin
          cnt_d  = CNT_MAX;
          tgt_we = 1'b1;
        end else if (bus.id_taken) begin
          if (cnt_q[r_idx] != CNT_MAX) cnt_d = cnt_q[r_idx] + CNT_W'(1);
          tgt_we = 1'b1;
        end else begin
          if (cnt_q[r_idx] != '0) cnt_d = cnt_q[r_idx] - CNT_W'(1);
        end
      end else if (bus.id_taken) begin
        alloc  = 1'b1;
        cnt_we = 1'b1;
        tgt_we = 1'b1;
        cnt_d  = bus.id_is_jump ? CNT_MAX : CNT_WEAK;
      end
    end
  end

  // PC, valid bits and counters all reset asynchronously.
  // Clearing the valid bits discards every trained entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '{default: 1'b0};
      cnt_q   <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      if (alloc)  valid_q[r_idx] <= 1'b1;
      if (cnt_we) cnt_q[r_idx]   <= cnt_d;
    end
  end

  // Tag and target storage needs no reset, because an entry is only used when its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc)  tag_q[r_idx] <= r_tag;
    if (tgt_we) tgt_q[r_idx] <= bus.id_target;
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispred_q;

  // Free-running event counters. They wrap at 2^32 and are cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (acc)        stat_resolved_q <= stat_resolved_q + 32'd1;
      if (mispredict) stat_mispred_q  <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_bp_next_pc.sv
// Testbench for bp_next_pc.
// It applies a directed vector table with hand-derived expectations, then a
// mid-run reset sequence, then random traffic. Outputs are compared with a
// behavioural BTB model.
module tb_bp_next_pc;
  localparam int ENT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bp_next_pc_if #(.PC_W(32)) bus ();

`ifdef BP_STATS_EN
  logic [31:0] st_res, st_mis;
`endif

  bp_next_pc #(.PC_W(32), .ENTRIES(ENT), .CNT_W(2), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef BP_STATS_EN
    ,
    .stat_resolved (st_res),
    .stat_mispred  (st_mis)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic hz; logic iv; logic [31:0] ipc; logic ij; logic it; logic [31:0] itgt;
    logic ipt; logic [31:0] iptgt;
    logic [31:0] e_pc; logic e_pt; logic [31:0] e_ptgt; logic e_fl;
  } vec_t;

  function automatic vec_t mk(logic hz, logic iv, logic [31:0] ipc, logic ij, logic it,
                              logic [31:0] itgt, logic ipt, logic [31:0] iptgt,
                              logic [31:0] e_pc, logic e_pt, logic [31:0] e_ptgt, logic e_fl);
    vec_t v;
    v.hz = hz; v.iv = iv; v.ipc = ipc; v.ij = ij; v.it = it; v.itgt = itgt;
    v.ipt = ipt; v.iptgt = iptgt;
    v.e_pc = e_pc; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic drive(input logic hz, input logic iv, input logic [31:0] ipc, input logic ij,
                       input logic it, input logic [31:0] itgt, input logic ipt,
                       input logic [31:0] iptgt);
    bus.hazard = hz; bus.id_valid = iv; bus.id_pc = ipc; bus.id_is_jump = ij;
    bus.id_taken = it; bus.id_target = itgt; bus.id_pred_taken = ipt;
    bus.id_pred_target = iptgt;
  endtask

  int exp_res = 0;
  int exp_mis = 0;

  task automatic apply(input vec_t v, input string tag, input int r);
    drive(v.hz, v.iv, v.ipc, v.ij, v.it, v.itgt, v.ipt, v.iptgt);
    #2;
    chk($sformatf("%s%0d.pc", tag, r), bus.pc, v.e_pc);
    chk($sformatf("%s%0d.pred_taken", tag, r), {31'd0, bus.pred_taken}, {31'd0, v.e_pt});
    chk($sformatf("%s%0d.pred_target", tag, r), bus.pred_target, v.e_ptgt);
    chk($sformatf("%s%0d.flush", tag, r), {31'd0, bus.flush}, {31'd0, v.e_fl});
    if (v.iv && !v.hz) exp_res++;
    if (v.e_fl) exp_mis++;
    @(posedge clk); #1;
  endtask

  // Behavioural reference: per-slot records with integer counters.
  logic        m_v   [ENT];
  logic [31:0] m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_cnt [ENT];
  logic [31:0] m_pc;
  int          m_res, m_mis;

  function automatic int slot(logic [31:0] a);
    return int'((a / 4) % ENT);
  endfunction

  function automatic logic [31:0] tagof(logic [31:0] a);
    return a / (4 * ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 1'b0; m_cnt[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_pc = 32'h0; m_res = 0; m_mis = 0;
  endtask

  vec_t tbl[$];
  vec_t post[$];

  initial begin
    logic [31:0] npc, ptgt, ipc, itgt, iptgt;
    logic hz, iv, ij, it, ipt, hit, pt, acc, mis, rh;
    int fi, ri;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", bus.pc, 32'h0);
    chk("reset.pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("reset.pred_target", bus.pred_target, 32'h4);
    chk("reset.flush", {31'd0, bus.flush}, 32'd0);
    rst = 1'b1;

    //             hz iv ipc    ij it itgt          ipt iptgt | pc          pt ptgt   fl
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h00,     0, 32'h04, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h04,     0, 32'h08, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h08,     0, 32'h0C, 0));
    tbl.push_back(mk(0, 1, 32'h10, 0, 1, 32'h40,       0, 32'h14, 32'h0C,     0, 32'h10, 1));
    tbl.push_back(mk(0, 1, 32'h0C, 1, 1, 32'h10,       0, 0,     32'h40,     0, 32'h44, 1));
    tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0,            1, 32'h40, 32'h10,     1, 32'h40, 1));
    tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0,            0, 32'h14, 32'h14,     0, 32'h18, 0));
    tbl.push_back(mk(0, 1, 32'h08, 1, 1, 32'h10,       0, 0,     32'h18,     0, 32'h1C, 1));
    tbl.push_back(mk(0, 1, 32'h10, 0, 1, 32'h40,       0, 32'h14, 32'h10,     0, 32'h40, 1));
    tbl.push_back(mk(0, 1, 32'h0C, 1, 1, 32'h10,       0, 0,     32'h40,     0, 32'h44, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h10,     0, 32'h40, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h14,     0, 32'h18, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h18,     0, 32'h1C, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h1C,     0, 32'h20, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0,            0, 0,     32'h20,     0, 32'h24, 0));
    tbl.push_back(mk(1, 1, 32'h10, 0, 1, 32'h80,       0, 0,     32'h20,     0, 32'h24, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h20,     0, 32'h24, 0));
    tbl.push_back(mk(0, 1, 32'h0C, 1, 1, 32'h10,       0, 0,     32'h24,     0, 32'h28, 1));
    tbl.push_back(mk(0, 1, 32'h10, 0, 1, 32'h40,       0, 0,     32'h10,     0, 32'h40, 1));
    tbl.push_back(mk(0, 1, 32'h0C, 1, 1, 32'h50,       0, 0,     32'h40,     0, 32'h44, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h50,     0, 32'h54, 0));
    tbl.push_back(mk(0, 1, 32'h0C, 1, 1, 32'hFFFF_FFFC, 0, 0,     32'h54,     0, 32'h58, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'hFFFF_FFFC, 0, 32'h00, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0,     32'h00,     0, 32'h04, 0));

    foreach (tbl[r]) apply(tbl[r], "row", r);

`ifdef BP_STATS_EN
    chk("stat_resolved", st_res, 32'(exp_res));
    chk("stat_mispred", st_mis, 32'(exp_mis));
`endif

    // Assert reset in the middle of a cycle. The PC and the table must clear without waiting for a clock edge.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst.pc", bus.pc, 32'h0);
    chk("midrst.pred_target", bus.pred_target, 32'h4);
    chk("midrst.flush", {31'd0, bus.flush}, 32'd0);
`ifdef BP_STATS_EN
    chk("midrst.stat_resolved", st_res, 32'd0);
    chk("midrst.stat_mispred", st_mis, 32'd0);
`endif
    @(posedge clk); #1;
    chk("midrst.hold_pc", bus.pc, 32'h0);
    rst = 1'b1;

    // Jump back to 0x10. Its earlier training was discarded, so it now predicts not-taken.
    post.push_back(mk(0, 1, 32'h0C, 1, 1, 32'h10, 0, 0, 32'h00, 0, 32'h04, 1));
    post.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0, 32'h10, 0, 32'h14, 0));
    post.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0, 32'h14, 0, 32'h18, 0));
    foreach (post[r]) apply(post[r], "post", r);

    // Randomized phase starting from a fresh reset.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      hz    = ($urandom % 5) == 0;
      iv    = ($urandom % 2) == 0;
      ipc   = (($urandom % 24) * 4) | ((($urandom % 3) == 0) ? 32'h100 : 32'h0);
      ij    = ($urandom % 4) == 0;
      it    = ij ? 1'b1 : 1'(($urandom % 2));
      itgt  = ($urandom % 64) * 4;
      ipt   = 1'($urandom % 2);
      iptgt = (($urandom % 2) == 0) ? itgt : (($urandom % 64) * 4);
      drive(hz, iv, ipc, ij, it, itgt, ipt, iptgt);

      fi   = slot(m_pc);
      hit  = m_v[fi] && (m_tag[fi] == tagof(m_pc));
      pt   = hit && (m_cnt[fi] >= 2);
      ptgt = hit ? m_tgt[fi] : m_pc + 32'd4;
      acc  = iv && !hz;
      mis  = acc && ((it != ipt) || (it && (itgt != iptgt)));

      #2;
      chk($sformatf("rnd%0d.pc", c), bus.pc, m_pc);
      chk($sformatf("rnd%0d.pred_taken", c), {31'd0, bus.pred_taken}, {31'd0, pt});
      chk($sformatf("rnd%0d.pred_target", c), bus.pred_target, ptgt);
      chk($sformatf("rnd%0d.flush", c), {31'd0, bus.flush}, {31'd0, mis});

      if (mis)     npc = it ? itgt : ipc + 32'd4;
      else if (hz) npc = m_pc;
      else if (pt) npc = ptgt;
      else         npc = m_pc + 32'd4;

      if (acc) begin
        ri = slot(ipc);
        rh = m_v[ri] && (m_tag[ri] == tagof(ipc));
        if (rh) begin
          if (ij) begin
            m_cnt[ri] = 3; m_tgt[ri] = itgt;
          end else if (it) begin
            m_cnt[ri] = (m_cnt[ri] < 3) ? m_cnt[ri] + 1 : 3; m_tgt[ri] = itgt;
          end else begin
            m_cnt[ri] = (m_cnt[ri] > 0) ? m_cnt[ri] - 1 : 0;
          end
        end else if (it) begin
          m_v[ri] = 1'b1; m_tag[ri] = tagof(ipc); m_tgt[ri] = itgt;
          m_cnt[ri] = ij ? 3 : 2;
        end
        m_res++;
      end
      if (mis) m_mis++;
      m_pc = npc;
      @(posedge clk); #1;
    end

`ifdef BP_STATS_EN
    chk("rnd.stat_resolved", st_res, 32'(m_res));
    chk("rnd.stat_mispred", st_mis, 32'(m_mis));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
